// File: rtl/free_list.sv
// Physical-register free list for the rename stage.
// 64-entry circular buffer of 6-bit tags. The head tag is shown without
// delay, one tag is popped per cycle, and up to two retiring tags are
// released per cycle. Tag 0 is never treated as free.
// Optional feature: define FREE_LIST_CHECK_EN to add an in-list bitmap.
// The bitmap rejects a release of a tag that is already free and sets err.
module free_list (
    input  logic       clk,
    input  logic       rstn,
    input  logic       alloc_req,
    output logic [5:0] alloc_tag,
    output logic       alloc_valid,
    output logic       stall,
    input  logic       rel_en_1,
    input  logic [5:0] rel_tag_1,
    input  logic       rel_en_2,
    input  logic [5:0] rel_tag_2,
    output logic [6:0] count,
    output logic       err
);

    logic [5:0] storage_q [64];
    logic [5:0] head_q, head_d;
    logic [5:0] tail_q, tail_d;
    logic [6:0] count_q, count_d;
    logic       err_q, err_d;

    logic       pop;
    logic [6:0] space;
    logic       req_1, req_2;
    logic       dup_1, dup_2;
    logic       acc_1, acc_2;
    logic [5:0] wr_idx_2;

`ifdef FREE_LIST_CHECK_EN
    logic [63:0] inlist_q, inlist_d;
`endif

    // The head entry is shown directly, so a pop has zero latency.
    assign alloc_tag   = storage_q[head_q];
    assign alloc_valid = (count_q != 7'd0);
    assign stall       = alloc_req && !alloc_valid;
    assign count       = count_q;
    assign err         = err_q;

    // Decide which requests are accepted on this edge.
    // The pop frees its slot before the releases compete for space.
    always_comb begin
        pop   = alloc_req && alloc_valid;
        space = 7'd64 - count_q + {6'd0, pop};
        req_1 = rel_en_1 && (rel_tag_1 != 6'd0);
        req_2 = rel_en_2 && (rel_tag_2 != 6'd0);
        dup_1 = 1'b0;
        dup_2 = 1'b0;
`ifdef FREE_LIST_CHECK_EN
        // A tag that is popped on this edge has already left the list.
        dup_1 = inlist_q[rel_tag_1] && !(pop && (alloc_tag == rel_tag_1));
`endif
        acc_1 = req_1 && !dup_1 && (space != 7'd0);
`ifdef FREE_LIST_CHECK_EN
        // If both slots name the same tag, the slot-1 copy wins.
        dup_2 = (inlist_q[rel_tag_2] && !(pop && (alloc_tag == rel_tag_2)))
              || (acc_1 && (rel_tag_1 == rel_tag_2));
`endif
        acc_2    = req_2 && !dup_2 && (space > {6'd0, acc_1});
        wr_idx_2 = tail_q + {5'd0, acc_1};
        head_d   = head_q + {5'd0, pop};
        tail_d   = tail_q + {5'd0, acc_1} + {5'd0, acc_2};
        count_d  = count_q + {6'd0, acc_1} + {6'd0, acc_2} - {6'd0, pop};
        // err is sticky. Tag-0 releases are simply ignored and do not set it.
        err_d    = err_q || (req_1 && !acc_1) || (req_2 && !acc_2);
    end

`ifdef FREE_LIST_CHECK_EN
    // Bitmap next state: the pop clears its bit first, then releases set bits.
    always_comb begin
        inlist_d = inlist_q;
        if (pop)   inlist_d[alloc_tag] = 1'b0;
        if (acc_1) inlist_d[rel_tag_1] = 1'b1;
        if (acc_2) inlist_d[wr_idx_2 == tail_q ? rel_tag_2 : rel_tag_2] = 1'b1;
    end

    // The bitmap starts with tags 32..63 free.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) inlist_q <= {{32{1'b1}}, {32{1'b0}}};
        else       inlist_q <= inlist_d;
    end
`endif

    // Pointers, occupancy and the error flag.
    // Reset leaves tags 32..63 free.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head_q  <= 6'd0;
            tail_q  <= 6'd32;
            count_q <= 7'd32;
            err_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    // Tag storage. Slot 1 writes at tail.
    // Slot 2 writes at the next free position after slot 1.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < 64; i++) begin
                storage_q[i] <= (i < 32) ? 6'(i + 32) : 6'd0;
            end
        end else begin
            if (acc_1) storage_q[tail_q]   <= rel_tag_1;
            if (acc_2) storage_q[wr_idx_2] <= rel_tag_2;
        end
    end

endmodule

// File: tb/tb_free_list.sv
// Self-checking bench for free_list.
// The reference model is a queue of free tags. Pops take the front entry.
// Accepted releases are appended in slot order. Capacity is 64.
// Define FREE_LIST_CHECK_EN for both the bench and the design to check
// duplicate-release rejection.
module tb_free_list;

    logic       clk;
    logic       rstn;
    logic       alloc_req;
    logic [5:0] alloc_tag;
    logic       alloc_valid;
    logic       stall;
    logic       rel_en_1;
    logic [5:0] rel_tag_1;
    logic       rel_en_2;
    logic [5:0] rel_tag_2;
    logic [6:0] count;
    logic       err;

    int n_checks = 0;
    int n_errors = 0;
    int n_txn    = 0;

    logic [5:0] m_q [$];
    bit         m_err;

    free_list dut (
        .clk         (clk),
        .rstn        (rstn),
        .alloc_req   (alloc_req),
        .alloc_tag   (alloc_tag),
        .alloc_valid (alloc_valid),
        .stall       (stall),
        .rel_en_1    (rel_en_1),
        .rel_tag_1   (rel_tag_1),
        .rel_en_2    (rel_en_2),
        .rel_tag_2   (rel_tag_2),
        .count       (count),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global time bound so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic bit m_contains(input logic [5:0] t);
        foreach (m_q[k]) if (m_q[k] == t) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit m_is_dup(input logic [5:0] t);
`ifdef FREE_LIST_CHECK_EN
        return m_contains(t);
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        m_q.delete();
        for (int i = 0; i < 32; i++) m_q.push_back(6'(32 + i));
        m_err = 1'b0;
    endtask

    // Apply one release to the model. Capacity counts the pop already done.
    task automatic model_release(input logic en, input logic [5:0] t);
        if (en && t != 6'd0) begin
            if (m_is_dup(t) || m_q.size() >= 64) m_err = 1'b1;
            else m_q.push_back(t);
        end
    endtask

    // Drive inputs just after the falling edge, then let them settle.
    task automatic drive(input bit req, input bit e1, input logic [5:0] t1,
                         input bit e2, input logic [5:0] t2);
        @(negedge clk);
        alloc_req = req;
        rel_en_1  = e1;
        rel_tag_1 = t1;
        rel_en_2  = e2;
        rel_tag_2 = t2;
        #1;
    endtask

    // Advance the model for the inputs being driven, then cross the edge.
    task automatic tick();
        n_txn++;
        $display("txn %0d: req=%0b rel1=%0b/%0d rel2=%0b/%0d count=%0d tag=%0d",
                 n_txn, alloc_req, rel_en_1, rel_tag_1, rel_en_2, rel_tag_2,
                 count, alloc_tag);
        if (alloc_req && m_q.size() != 0) void'(m_q.pop_front());
        model_release(rel_en_1, rel_tag_1);
        model_release(rel_en_2, rel_tag_2);
        @(posedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        alloc_req = 0; rel_en_1 = 0; rel_tag_1 = 0; rel_en_2 = 0; rel_tag_2 = 0;
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        model_reset();
    endtask

    // Reset asserted mid-cycle with requests pending: nothing may leak through.
    task automatic test_reset();
        @(negedge clk);
        rstn = 1'b1;
        alloc_req = 1; rel_en_1 = 1; rel_tag_1 = 6'd5; rel_en_2 = 1; rel_tag_2 = 6'd9;
        #2;
        rstn = 1'b0;
        #1;
        n_checks++; if (count !== 7'd32) begin n_errors++; $display("FAIL reset_count: got %0d want 32", count); end
        n_checks++; if (alloc_tag !== 6'd32) begin n_errors++; $display("FAIL reset_tag: got %0d want 32", alloc_tag); end
        n_checks++; if (alloc_valid !== 1'b1) begin n_errors++; $display("FAIL reset_valid: got %0b want 1", alloc_valid); end
        n_checks++; if (stall !== 1'b0) begin n_errors++; $display("FAIL reset_stall: got %0b want 0", stall); end
        n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL reset_err: got %0b want 0", err); end
        @(posedge clk);
        #1;
        n_checks++; if (count !== 7'd32) begin n_errors++; $display("FAIL reset_hold_count: got %0d want 32", count); end
        n_checks++; if (alloc_tag !== 6'd32) begin n_errors++; $display("FAIL reset_hold_tag: got %0d want 32", alloc_tag); end
        @(negedge clk);
        alloc_req = 0; rel_en_1 = 0; rel_tag_1 = 0; rel_en_2 = 0; rel_tag_2 = 0;
        rstn = 1'b1;
        model_reset();
    endtask

    // Three consecutive pops from reset.
    task automatic test_alloc3();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 0, 0);
            n_checks++; if (alloc_tag !== 6'(32 + i)) begin n_errors++; $display("FAIL alloc3_tag: got %0d want %0d", alloc_tag, 32 + i); end
            n_checks++; if (count !== 7'(32 - i)) begin n_errors++; $display("FAIL alloc3_count: got %0d want %0d", count, 32 - i); end
            tick();
        end
        drive(0, 0, 0, 0, 0);
        n_checks++; if (alloc_tag !== 6'd35) begin n_errors++; $display("FAIL alloc3_next: got %0d want 35", alloc_tag); end
        n_checks++; if (count !== 7'd29) begin n_errors++; $display("FAIL alloc3_final_count: got %0d want 29", count); end
    endtask

    // Dual release, then drain. Continues into a release while empty.
    task automatic test_dual_release_and_empty();
        logic [5:0] obs [$];
        do_reset();
        drive(0, 1, 6'd5, 1, 6'd9);
        n_checks++; if (count !== 7'd32) begin n_errors++; $display("FAIL dual_pre_count: got %0d want 32", count); end
        tick();
        drive(0, 0, 0, 0, 0);
        n_checks++; if (count !== 7'd34) begin n_errors++; $display("FAIL dual_post_count: got %0d want 34", count); end
        for (int k = 0; k < 70 && m_q.size() != 0; k++) begin
            drive(1, 0, 0, 0, 0);
            n_checks++; if (alloc_tag !== m_q[0]) begin n_errors++; $display("FAIL drain_tag: got %0d want %0d", alloc_tag, m_q[0]); end
            obs.push_back(alloc_tag);
            tick();
        end
        n_checks++;
        if (obs.size() != 34) begin
            n_errors++; $display("FAIL drain_len: got %0d want 34", obs.size());
        end else if (obs[31] !== 6'd63 || obs[32] !== 6'd5 || obs[33] !== 6'd9) begin
            n_errors++; $display("FAIL drain_tail_order: got %0d,%0d,%0d want 63,5,9", obs[31], obs[32], obs[33]);
        end
        drive(1, 1, 6'd7, 0, 0);
        n_checks++; if (count !== 7'd0) begin n_errors++; $display("FAIL empty_count: got %0d want 0", count); end
        n_checks++; if (stall !== 1'b1) begin n_errors++; $display("FAIL empty_stall: got %0b want 1", stall); end
        n_checks++; if (alloc_valid !== 1'b0) begin n_errors++; $display("FAIL empty_valid: got %0b want 0", alloc_valid); end
        tick();
        drive(0, 0, 0, 0, 0);
        n_checks++; if (alloc_valid !== 1'b1) begin n_errors++; $display("FAIL empty_next_valid: got %0b want 1", alloc_valid); end
        n_checks++; if (alloc_tag !== 6'd7) begin n_errors++; $display("FAIL empty_next_tag: got %0d want 7", alloc_tag); end
        n_checks++; if (count !== 7'd1) begin n_errors++; $display("FAIL empty_next_count: got %0d want 1", count); end
    endtask

    // Tag-0 releases are ignored and do not set err.
    task automatic test_zero_tag();
        do_reset();
        drive(0, 1, 6'd0, 1, 6'd0);
        tick();
        drive(0, 0, 0, 0, 0);
        n_checks++; if (count !== 7'd32) begin n_errors++; $display("FAIL zero_count: got %0d want 32", count); end
        n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL zero_err: got %0b want 0", err); end
    endtask

    // Release tag 40, which is already free after reset.
    task automatic test_dup40();
        do_reset();
        drive(0, 1, 6'd40, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0);
`ifdef FREE_LIST_CHECK_EN
        n_checks++; if (count !== 7'd32) begin n_errors++; $display("FAIL dup40_count: got %0d want 32", count); end
        n_checks++; if (err !== 1'b1) begin n_errors++; $display("FAIL dup40_err: got %0b want 1", err); end
        tick();
        drive(0, 0, 0, 0, 0);
        n_checks++; if (err !== 1'b1) begin n_errors++; $display("FAIL dup40_sticky: got %0b want 1", err); end
`else
        n_checks++; if (count !== 7'd33) begin n_errors++; $display("FAIL dup40_count: got %0d want 33", count); end
        n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL dup40_err: got %0b want 0", err); end
`endif
    endtask

`ifndef FREE_LIST_CHECK_EN
    // Fill to 64, overflow, then pop plus two releases at full.
    // Without the bitmap the list can reach 64, because duplicates are accepted.
    task automatic test_overflow();
        logic [5:0] last;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive(0, 1, 6'(i + 1), 1, 6'(i + 17));
            tick();
        end
        drive(0, 1, 6'd3, 1, 6'd4);
        n_checks++; if (count !== 7'd64) begin n_errors++; $display("FAIL full_count: got %0d want 64", count); end
        n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL full_err_pre: got %0b want 0", err); end
        tick();
        drive(1, 1, 6'd10, 1, 6'd11);
        n_checks++; if (count !== 7'd64) begin n_errors++; $display("FAIL overflow_count: got %0d want 64", count); end
        n_checks++; if (err !== 1'b1) begin n_errors++; $display("FAIL overflow_err: got %0b want 1", err); end
        n_checks++; if (alloc_tag !== 6'd32) begin n_errors++; $display("FAIL full_pop_tag: got %0d want 32", alloc_tag); end
        tick();
        last = 6'd0;
        for (int k = 0; k < 70 && m_q.size() != 0; k++) begin
            drive(1, 0, 0, 0, 0);
            n_checks++; if (alloc_tag !== m_q[0]) begin n_errors++; $display("FAIL full_drain_tag: got %0d want %0d", alloc_tag, m_q[0]); end
            last = alloc_tag;
            tick();
        end
        n_checks++; if (last !== 6'd10) begin n_errors++; $display("FAIL full_last_tag: got %0d want 10", last); end
    endtask
`endif

    // More than 64 pop/release pairs: both pointers wrap.
    task automatic test_wrap();
        logic [5:0] t;
        do_reset();
        for (int i = 0; i < 70; i++) begin
            t = m_q[0];
            drive(1, 1, t, 0, 0);
            n_checks++; if (alloc_tag !== t) begin n_errors++; $display("FAIL wrap_tag: got %0d want %0d", alloc_tag, t); end
            n_checks++; if (count !== 7'd32) begin n_errors++; $display("FAIL wrap_count: got %0d want 32", count); end
            tick();
        end
        drive(0, 0, 0, 0, 0);
        n_checks++; if (err !== 1'b0) begin n_errors++; $display("FAIL wrap_err: got %0b want 0", err); end
        n_checks++; if (alloc_tag !== m_q[0]) begin n_errors++; $display("FAIL wrap_end_tag: got %0d want %0d", alloc_tag, m_q[0]); end
    endtask

    // Random traffic. A release-heavy phase is followed by a pop-heavy phase.
    task automatic test_random();
        bit req, e1, e2;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            if (i < 200) begin
                req = ($urandom_range(0, 3) == 0);
                e1  = ($urandom_range(0, 1) == 1);
                e2  = ($urandom_range(0, 1) == 1);
            end else begin
                req = ($urandom_range(0, 3) != 0);
                e1  = ($urandom_range(0, 3) == 0);
                e2  = ($urandom_range(0, 3) == 0);
            end
            drive(req, e1, 6'($urandom_range(0, 63)), e2, 6'($urandom_range(0, 63)));
            n_checks++; if (count !== 7'(m_q.size())) begin n_errors++; $display("FAIL rand_count: got %0d want %0d", count, m_q.size()); end
            n_checks++; if (alloc_valid !== (m_q.size() != 0)) begin n_errors++; $display("FAIL rand_valid: got %0b want %0b", alloc_valid, m_q.size() != 0); end
            n_checks++; if (stall !== (req && m_q.size() == 0)) begin n_errors++; $display("FAIL rand_stall: got %0b want %0b", stall, req && m_q.size() == 0); end
            n_checks++; if (err !== m_err) begin n_errors++; $display("FAIL rand_err: got %0b want %0b", err, m_err); end
            if (m_q.size() != 0) begin
                n_checks++; if (alloc_tag !== m_q[0]) begin n_errors++; $display("FAIL rand_tag: got %0d want %0d", alloc_tag, m_q[0]); end
            end
            tick();
        end
    endtask

    initial begin
        rstn = 1'b0;
        alloc_req = 0; rel_en_1 = 0; rel_tag_1 = 0; rel_en_2 = 0; rel_tag_2 = 0;
        model_reset();
        test_reset();
        test_alloc3();
        test_dual_release_and_empty();
        test_zero_tag();
        test_dup40();
`ifndef FREE_LIST_CHECK_EN
        test_overflow();
`endif
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/free_list.md
FREE_LIST -- requirements
Module: free_list

Interface
REQ-001 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port rstn  input  1  reset, asynchronous and active-low.
REQ-003 SHALL have port alloc_req  input  1  rename stage consumes the head tag this cycle.
REQ-004 SHALL have port alloc_tag  output  6  physical register tag at the list head.
REQ-005 SHALL have port alloc_valid  output  1  alloc_tag is valid; equals count != 0.
REQ-006 SHALL have port stall  output  1  combinational; equals alloc_req && !alloc_valid.
REQ-007 SHALL have port rel_en_1  input  1  retire slot 1 frees a register; driven by the retire stage's bc_1.
REQ-008 SHALL have port rel_tag_1  input  6  tag freed by slot 1; driven by the retire stage's old_reg_1.
REQ-009 SHALL have port rel_en_2  input  1  retire slot 2 frees a register; driven by bc_2.
REQ-010 SHALL have port rel_tag_2  input  6  tag freed by slot 2; driven by old_reg_2.
REQ-011 SHALL have port count  output  7  number of free tags held, range 0..64.
REQ-012 SHALL have port err  output  1  sticky illegal-release flag (see Configuration).

Function
REQ-013 SHALL hold free tags in a 64-entry circular buffer of 6-bit entries, with 6-bit head and tail pointers that wrap 63->0.
REQ-014 SHALL present storage[head] on alloc_tag combinationally (first-word fall-through); pop latency is zero, and the next tag appears the cycle after a pop.
REQ-015 SHALL pop on a clock edge only when alloc_req && alloc_valid; head then advances by 1 modulo 64.
REQ-016 SHALL ignore a release whose tag is 0 (p0 is never free; 0 means no register).
REQ-017 SHALL write an accepted slot-1 release to storage[tail], and an accepted slot-2 release to the next free position after it (tail, or tail+1 if slot 1 was also accepted); tail then advances by the number of accepted releases.
REQ-018 SHALL update count on every edge as count + accepted releases - pop.
REQ-019 SHALL NOT bypass a same-cycle release to alloc_tag when empty; a release into an empty list becomes visible on the next cycle.
REQ-020 SHALL drop any release that would make count exceed 64 (slot 1 takes priority) and set err.
REQ-021 SHALL allow pop and up to two releases on the same edge, including when count == 64 (the pop frees a slot first).

Reset
REQ-022 SHALL, while rstn is low, asynchronously set storage[i] = 32+i for i = 0..31, leave storage[32..63] = 0, head = 0, tail = 32, count = 32 and err = 0.
REQ-023 SHALL, as a result of that reset state, drive alloc_tag = 32, alloc_valid = 1 and stall = alloc_req && 0 = 0 during reset.
REQ-024 SHALL discard any pop or release in flight when reset asserts; no partial update survives.

Configuration
REQ-025 SHALL, with FREE_LIST_CHECK_EN defined, keep a 64-bit in-list bitmap: set on accepted release, cleared on pop, reset with bits 32..63 = 1 and all others 0.
REQ-026 SHALL, with FREE_LIST_CHECK_EN defined, drop and set err for any release of a tag already in the list, including both slots naming the same tag in one cycle (slot 2 is then dropped).
REQ-027 SHALL, without FREE_LIST_CHECK_EN, have no bitmap, accept duplicate releases, and set err only under REQ-020.

Verification
REQ-028 SHALL cover: reset, then alloc_req high for 3 cycles -> alloc_tag 32, 33, 34, then 35 shown; count goes 32->29.
REQ-029 SHALL cover: rel_en_1=1 tag 5 and rel_en_2=1 tag 9 in one cycle, then drain the list -> 5 and 9 pop after tag 63, in that order; count +2 on the release edge.
REQ-030 SHALL cover: drain to count=0, then alloc_req=1 with rel_en_1 tag 7 on the same edge -> stall=1 that cycle; next cycle alloc_tag=7, alloc_valid=1.
REQ-031 SHALL cover: rel_en_1=1 with rel_tag_1=0 -> count unchanged, err=0.
REQ-032 SHALL cover: with FREE_LIST_CHECK_EN, release of tag 40 at reset -> dropped, err=1 and sticky; without the macro, count becomes 33 and err stays 0.
REQ-033 SHALL cover: run more than 64 pop/release pairs -> head and tail wrap, count stays constant and tag order is preserved.
